// File: rtl/decode_input_buffer.sv
// Fetch-to-decode input buffer: DEPTH-entry FIFO with registered ready,
// registered head outputs, per-entry RVC-illegal flag and single-cycle flush.
module decode_input_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [WIDTH-1:0] s_instruction,
    input  logic [WIDTH-1:0] s_program_counter,
    input  logic             s_branch_pred,
    input  logic             flush,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_instruction,
    output logic [WIDTH-1:0] m_program_counter,
    output logic             m_branch_pred,
    output logic             m_illegal,
    output logic [31:0]      accepted_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    function automatic logic is_compressed(input logic [1:0] lsb);
        return (lsb != 2'b11);
    endfunction

    logic [WIDTH-1:0] mem_instr_q [DEPTH];
    logic [WIDTH-1:0] mem_instr_d [DEPTH];
    logic [WIDTH-1:0] mem_pc_q    [DEPTH];
    logic [WIDTH-1:0] mem_pc_d    [DEPTH];
    logic             mem_pred_q  [DEPTH];
    logic             mem_pred_d  [DEPTH];
    logic             mem_ill_q   [DEPTH];
    logic             mem_ill_d   [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic             ready_q, ready_d;
    logic [31:0]      acc_q, acc_d;
    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_instr_q, m_instr_d;
    logic [WIDTH-1:0] m_pc_q, m_pc_d;
    logic             m_pred_q, m_pred_d;
    logic             m_ill_q, m_ill_d;

    logic             push_s;
    logic             pop_s;
    logic             in_ill_s;

    // Next-state computation for FIFO storage, pointers, ready and head outputs
    always_comb begin
        push_s   = s_tvalid & ready_q & ~flush;
        pop_s    = m_valid_q & m_tready & ~flush;
        in_ill_s = is_compressed(s_instruction[1:0]);

        mem_instr_d = mem_instr_q;
        mem_pc_d    = mem_pc_q;
        mem_pred_d  = mem_pred_q;
        mem_ill_d   = mem_ill_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        ready_d     = ready_q;
        acc_d       = acc_q;
        m_valid_d   = m_valid_q;
        m_instr_d   = m_instr_q;
        m_pc_d      = m_pc_q;
        m_pred_d    = m_pred_q;
        m_ill_d     = m_ill_q;

        if (flush) begin
            count_d   = {CW{1'b0}};
            rd_ptr_d  = {PW{1'b0}};
            wr_ptr_d  = {PW{1'b0}};
            ready_d   = 1'b1;
            m_valid_d = 1'b0;
        end else begin
            if (push_s) begin
                mem_instr_d[wr_ptr_q] = s_instruction;
                mem_pc_d[wr_ptr_q]    = s_program_counter;
                mem_pred_d[wr_ptr_q]  = s_branch_pred;
                mem_ill_d[wr_ptr_q]   = in_ill_s;
                wr_ptr_d              = wr_ptr_q + PW'(1);
                acc_d                 = acc_q + 32'd1;
            end else begin
                wr_ptr_d = wr_ptr_q;
                acc_d    = acc_q;
            end

            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            ready_d   = (count_d < DEPTH_C);
            m_valid_d = (count_d != {CW{1'b0}});

            // The beat written this cycle is not in storage yet; forward it when it becomes head
            if (push_s && (rd_ptr_d == wr_ptr_q)) begin
                m_instr_d = s_instruction;
                m_pc_d    = s_program_counter;
                m_pred_d  = s_branch_pred;
                m_ill_d   = in_ill_s;
            end else begin
                m_instr_d = mem_instr_q[rd_ptr_d];
                m_pc_d    = mem_pc_q[rd_ptr_d];
                m_pred_d  = mem_pred_q[rd_ptr_d];
                m_ill_d   = mem_ill_q[rd_ptr_d];
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr_q[i] <= {WIDTH{1'b0}};
                mem_pc_q[i]    <= {WIDTH{1'b0}};
                mem_pred_q[i]  <= 1'b0;
                mem_ill_q[i]   <= 1'b0;
            end
            count_q   <= {CW{1'b0}};
            rd_ptr_q  <= {PW{1'b0}};
            wr_ptr_q  <= {PW{1'b0}};
            ready_q   <= 1'b0;
            acc_q     <= 32'd0;
            m_valid_q <= 1'b0;
            m_instr_q <= {WIDTH{1'b0}};
            m_pc_q    <= {WIDTH{1'b0}};
            m_pred_q  <= 1'b0;
            m_ill_q   <= 1'b0;
        end else begin
            mem_instr_q <= mem_instr_d;
            mem_pc_q    <= mem_pc_d;
            mem_pred_q  <= mem_pred_d;
            mem_ill_q   <= mem_ill_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            ready_q     <= ready_d;
            acc_q       <= acc_d;
            m_valid_q   <= m_valid_d;
            m_instr_q   <= m_instr_d;
            m_pc_q      <= m_pc_d;
            m_pred_q    <= m_pred_d;
            m_ill_q     <= m_ill_d;
        end
    end

    assign s_tready          = ready_q;
    assign m_tvalid          = m_valid_q;
    assign m_instruction     = m_instr_q;
    assign m_program_counter = m_pc_q;
    assign m_branch_pred     = m_pred_q;
    assign m_illegal         = m_ill_q;
    assign accepted_count    = acc_q;

endmodule

// File: tb/tb_decode_input_buffer.sv
// Scoreboard bench for decode_input_buffer: directed scenarios plus a random stream.
module tb_decode_input_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic             clk;
    logic             rst_n;
    logic             s_tvalid;
    logic             s_tready;
    logic [WIDTH-1:0] s_instruction;
    logic [WIDTH-1:0] s_program_counter;
    logic             s_branch_pred;
    logic             flush;
    logic             m_tvalid;
    logic             m_tready;
    logic [WIDTH-1:0] m_instruction;
    logic [WIDTH-1:0] m_program_counter;
    logic             m_branch_pred;
    logic             m_illegal;
    logic [31:0]      accepted_count;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
        logic        ill;
    } beat_t;

    beat_t       exp_q[$];
    int          errors;
    int          checks;
    logic [31:0] exp_acc;
    logic [31:0] acc_before;

    decode_input_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_tvalid          (s_tvalid),
        .s_tready          (s_tready),
        .s_instruction     (s_instruction),
        .s_program_counter (s_program_counter),
        .s_branch_pred     (s_branch_pred),
        .flush             (flush),
        .m_tvalid          (m_tvalid),
        .m_tready          (m_tready),
        .m_instruction     (m_instruction),
        .m_program_counter (m_program_counter),
        .m_branch_pred     (m_branch_pred),
        .m_illegal         (m_illegal),
        .accepted_count    (accepted_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic pred);
        logic hs;
        logic done;
        done              = 1'b0;
        s_tvalid          = 1'b1;
        s_instruction     = instr;
        s_program_counter = pc;
        s_branch_pred     = pred;
        for (int i = 0; i < 50 && !done; i++) begin
            hs = s_tready;
            tick();
            done = hs;
        end
        check("send_accept", {63'd0, done}, 64'd1);
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        s_tvalid = 1'b0;
        flush    = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 20 && m_tvalid; i++) tick();
        check("drain_empty", {63'd0, m_tvalid}, 64'd0);
        check("sb_leftover", 64'(exp_q.size()), 64'd0);
        m_tready = 1'b0;
    endtask

    // Scoreboard: expectations enqueued on accepted beats, compared when decode consumes
    initial begin
        beat_t b;
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                exp_acc = 32'd0;
            end else if (flush) begin
                exp_q.delete();
            end else begin
                if (m_tvalid && m_tready) begin
                    check("sb_nonempty", {63'd0, exp_q.size() > 0}, 64'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("m_instruction", 64'(m_instruction), 64'(e.instr));
                        check("m_program_counter", 64'(m_program_counter), 64'(e.pc));
                        check("m_branch_pred", 64'(m_branch_pred), 64'(e.pred));
                        check("m_illegal", 64'(m_illegal), 64'(e.ill));
                    end
                end
                if (s_tvalid && s_tready) begin
                    b.instr = s_instruction;
                    b.pc    = s_program_counter;
                    b.pred  = s_branch_pred;
                    b.ill   = (s_instruction[1:0] != 2'b11);
                    exp_q.push_back(b);
                    exp_acc = exp_acc + 32'd1;
                end
            end
        end
    end

    initial begin
        errors            = 0;
        checks            = 0;
        exp_acc           = 32'd0;
        rst_n             = 1'b0;
        s_tvalid          = 1'b0;
        s_instruction     = 32'd0;
        s_program_counter = 32'd0;
        s_branch_pred     = 1'b0;
        flush             = 1'b0;
        m_tready          = 1'b0;
        #23;
        check("rst_s_tready", {63'd0, s_tready}, 64'd0);
        check("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
        check("rst_acc", 64'(accepted_count), 64'd0);
        check("rst_m_instr", 64'(m_instruction), 64'd0);

        // 1: release reset mid-cycle with a beat pending
        @(negedge clk);
        #2;
        rst_n             = 1'b1;
        s_tvalid          = 1'b1;
        s_instruction     = 32'h0000_0013;
        s_program_counter = 32'h0;
        #1;
        check("t1_ready_before_clk", {63'd0, s_tready}, 64'd0);
        tick();
        check("t1_ready_first_clk", {63'd0, s_tready}, 64'd1);
        check("t1_no_valid_yet", {63'd0, m_tvalid}, 64'd0);
        tick();
        s_tvalid = 1'b0;
        check("t1_valid_after_accept", {63'd0, m_tvalid}, 64'd1);
        check("t1_pc", 64'(m_program_counter), 64'h0);
        check("t1_acc", 64'(accepted_count), 64'd1);
        drain();

        // 2: backpressure with decode stalled, then ordered drain
        send(32'h0000_0013, 32'h0, 1'b0);
        send(32'h0000_0093, 32'h4, 1'b1);
        s_tvalid          = 1'b1;
        s_instruction     = 32'h0000_0113;
        s_program_counter = 32'h8;
        tick();
        check("t2_full_ready", {63'd0, s_tready}, 64'd0);
        check("t2_hold_pc", 64'(m_program_counter), 64'h0);
        check("t2_acc_full", 64'(accepted_count), 64'd3);
        m_tready = 1'b1;
        send(32'h0000_0113, 32'h8, 1'b0);
        drain();
        check("t2_acc", 64'(accepted_count), 64'd4);

        // 3: full buffer, simultaneous pop must not admit a push
        send(32'h0000_0213, 32'h10, 1'b0);
        send(32'h0000_0293, 32'h14, 1'b0);
        acc_before        = accepted_count;
        s_tvalid          = 1'b1;
        s_instruction     = 32'h0000_0313;
        s_program_counter = 32'h18;
        m_tready          = 1'b1;
        #1;
        check("t3_ready_full", {63'd0, s_tready}, 64'd0);
        tick();
        check("t3_ready_next", {63'd0, s_tready}, 64'd1);
        check("t3_acc_unchanged", 64'(accepted_count), 64'(acc_before));
        check("t3_head", 64'(m_program_counter), 64'h14);
        tick();
        s_tvalid = 1'b0;
        check("t3_new_head", 64'(m_program_counter), 64'h18);
        drain();
        check("t3_acc", 64'(accepted_count), 64'(acc_before + 32'd1));

        // 4: flush drops buffered and incoming beats
        send(32'h0000_0013, 32'h20, 1'b0);
        send(32'h0000_0013, 32'h24, 1'b1);
        acc_before        = accepted_count;
        flush             = 1'b1;
        s_tvalid          = 1'b1;
        s_program_counter = 32'h28;
        tick();
        flush    = 1'b0;
        s_tvalid = 1'b0;
        check("t4_valid", {63'd0, m_tvalid}, 64'd0);
        check("t4_ready", {63'd0, s_tready}, 64'd1);
        check("t4_acc", 64'(accepted_count), 64'(acc_before));
        send(32'h0000_0013, 32'h100, 1'b0);
        check("t4_first_pc", 64'(m_program_counter), 64'h100);
        drain();

        // 5: compressed encoding flagged illegal
        send(32'h0000_4501, 32'h200, 1'b0);
        check("t5_illegal", {63'd0, m_illegal}, 64'd1);
        drain();
        send(32'h0000_0013, 32'h204, 1'b0);
        check("t5_legal", {63'd0, m_illegal}, 64'd0);
        drain();

        // 6: asynchronous reset with one entry buffered
        send(32'h0000_0013, 32'h300, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid_async", {63'd0, m_tvalid}, 64'd0);
        check("t6_ready_async", {63'd0, s_tready}, 64'd0);
        check("t6_acc_async", 64'(accepted_count), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        check("t6_no_replay", {63'd0, m_tvalid}, 64'd0);

        // Random stream against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            s_tvalid          = 1'($urandom_range(0, 1));
            s_instruction     = $urandom;
            s_program_counter = $urandom;
            s_branch_pred     = 1'($urandom_range(0, 1));
            m_tready          = 1'($urandom_range(0, 1));
            flush             = ($urandom_range(0, 31) == 0);
            tick();
        end
        drain();
        check("rand_acc", 64'(accepted_count), 64'(exp_acc));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
